memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter.sv | 174 +++++++++++++++++
 tb/tb_memory_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin arbiter granting two requesters access to one memory port.
// Define MEMORY_ARBITER_TIMEOUT_EN to enable the wait-phase watchdog and the err pulse.
module memory_arbiter #(
    parameter int unsigned WORD_SIZE      = 8,
    parameter int unsigned ADDRESS_SIZE   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [1:0]                req,
    input  logic [1:0]                we,
    input  logic [2*ADDRESS_SIZE-1:0] addr,
    input  logic [2*WORD_SIZE-1:0]    wdata,
    output logic [1:0]                ack,
    output logic [WORD_SIZE-1:0]      rdata,
    output logic [1:0]                err,
    output logic                      mem_r_en,
    output logic                      mem_w_en,
    output logic [ADDRESS_SIZE-1:0]   mem_r_addr,
    output logic [ADDRESS_SIZE-1:0]   mem_w_addr,
    output logic [WORD_SIZE-1:0]      mem_w_data,
    input  logic [WORD_SIZE-1:0]      mem_r_data,
    input  logic                      mem_r_ready,
    input  logic                      mem_w_ready
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    state_e                  state_q, state_d;
    logic                    win_q, win_d;
    logic                    last_q, last_d;
    logic                    we_q, we_d;
    logic                    r_en_q, r_en_d;
    logic                    w_en_q, w_en_d;
    logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0]    wdata_q, wdata_d;
    logic [WORD_SIZE-1:0]    rdata_q, rdata_d;
    logic [1:0]              ack_q, ack_d;

    logic                    grant_c;
    logic                    ready_c;
    logic [1:0]              onehot_c;

`ifdef MEMORY_ARBITER_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [1:0]              err_q, err_d;
`endif

    // On a tie the requester not served last wins; last_q resets to B so A leads.
    assign grant_c  = (req == 2'b11) ? ~last_q : req[1];
    assign ready_c  = we_q ? mem_w_ready : mem_r_ready;
    assign onehot_c = win_q ? 2'b10 : 2'b01;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        last_d  = last_q;
        we_d    = we_q;
        r_en_d  = r_en_q;
        w_en_d  = w_en_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = 2'b00;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 2'b00;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    win_d   = grant_c;
                    last_d  = grant_c;
                    we_d    = grant_c ? we[1] : we[0];
                    addr_d  = grant_c ? addr[ADDRESS_SIZE +: ADDRESS_SIZE]
                                      : addr[0 +: ADDRESS_SIZE];
                    wdata_d = grant_c ? wdata[WORD_SIZE +: WORD_SIZE]
                                      : wdata[0 +: WORD_SIZE];
                    r_en_d  = ~we_d;
                    w_en_d  = we_d;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
`ifdef MEMORY_ARBITER_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                if (ready_c) begin
                    r_en_d  = 1'b0;
                    w_en_d  = 1'b0;
                    if (!we_q) begin
                        rdata_d = mem_r_data;
                    end
                    ack_d   = onehot_c;
                    state_d = DONE;
                end
`ifdef MEMORY_ARBITER_TIMEOUT_EN
                // Watchdog expiry completes the transaction with zeroed read data.
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    r_en_d  = 1'b0;
                    w_en_d  = 1'b0;
                    rdata_d = '0;
                    ack_d   = onehot_c;
                    err_d   = onehot_c;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            win_q   <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            r_en_q  <= 1'b0;
            w_en_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            last_q  <= last_d;
            we_q    <= we_d;
            r_en_q  <= r_en_d;
            w_en_q  <= w_en_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
        end
    end

`ifdef MEMORY_ARBITER_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 2'b00;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 2'b00;
`endif

    assign ack        = ack_q;
    assign rdata      = rdata_q;
    assign mem_r_en   = r_en_q;
    assign mem_w_en   = w_en_q;
    assign mem_r_addr = addr_q;
    assign mem_w_addr = addr_q;
    assign mem_w_data = wdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: scoreboard of expected acks plus per-scenario checks.
module tb_memory_arbiter;

    localparam int unsigned WS = 8;
    localparam int unsigned AS = 4;
    localparam int unsigned TO = 15;

    typedef struct packed {
        logic [1:0]    ack;
        logic [WS-1:0] rdata;
        logic [1:0]    err;
    } exp_t;

    logic            clock = 1'b0;
    logic            reset;
    logic [1:0]      req;
    logic [1:0]      we;
    logic [2*AS-1:0] addr;
    logic [2*WS-1:0] wdata;
    logic [1:0]      ack;
    logic [WS-1:0]   rdata;
    logic [1:0]      err;
    logic            mem_r_en, mem_w_en;
    logic [AS-1:0]   mem_r_addr, mem_w_addr;
    logic [WS-1:0]   mem_w_data, mem_r_data;
    logic            mem_r_ready, mem_w_ready;

    exp_t          sb[$];
    exp_t          mon_e;
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [WS-1:0] mem     [16];
    logic [WS-1:0] ref_mem [16];
    logic [WS-1:0] exp_rdata;
    logic          mem_hold;
    int            mem_wait;
    int            en_cnt = 0;
    logic          rdy_c;

    memory_arbiter #(
        .WORD_SIZE      (WS),
        .ADDRESS_SIZE   (AS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .ack         (ack),
        .rdata       (rdata),
        .err         (err),
        .mem_r_en    (mem_r_en),
        .mem_w_en    (mem_w_en),
        .mem_r_addr  (mem_r_addr),
        .mem_w_addr  (mem_w_addr),
        .mem_w_data  (mem_w_data),
        .mem_r_data  (mem_r_data),
        .mem_r_ready (mem_r_ready),
        .mem_w_ready (mem_w_ready)
    );

    always #5 clock = ~clock;

    // Memory model: ready rises after mem_wait cycles of WAIT, unless held off.
    always @(posedge clock) begin
        if (mem_r_en || mem_w_en) en_cnt <= en_cnt + 1;
        else en_cnt <= 0;
        if (mem_w_en && mem_w_ready) mem[mem_w_addr] <= mem_w_data;
    end
    assign rdy_c       = !mem_hold && (en_cnt > mem_wait);
    assign mem_w_ready = mem_w_en && rdy_c;
    assign mem_r_ready = mem_r_en && rdy_c;
    assign mem_r_data  = mem[mem_r_addr];

    // Scoreboard consumer: every ack must match the oldest expectation.
    always @(negedge clock) begin
        if (reset && (ack !== 2'b00 || err !== 2'b00)) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ack ack=%b err=%b rdata=%h", ack, err, rdata);
            end else begin
                mon_e = sb.pop_front();
                if (ack !== mon_e.ack || rdata !== mon_e.rdata || err !== mon_e.err) begin
                    n_fail++;
                    $display("FAIL sb_txn got ack=%b rdata=%h err=%b expected ack=%b rdata=%h err=%b",
                             ack, rdata, err, mon_e.ack, mon_e.rdata, mon_e.err);
                end
            end
        end
    end

    task automatic push_exp(input int idx, input bit w, input logic [AS-1:0] a,
                            input logic [WS-1:0] d, input bit to);
        exp_t e;
        if (to) exp_rdata = '0;
        else if (!w) exp_rdata = ref_mem[a];
        else ref_mem[a] = d;
        e.ack   = (idx == 1) ? 2'b10 : 2'b01;
        e.err   = to ? e.ack : 2'b00;
        e.rdata = exp_rdata;
        sb.push_back(e);
    endtask

    task automatic drive(input int idx, input bit w, input logic [AS-1:0] a,
                         input logic [WS-1:0] d);
        req[idx]               = 1'b1;
        we[idx]                = w;
        addr[idx*AS +: AS]     = a;
        wdata[idx*WS +: WS]    = d;
    endtask

    // One transaction from a single requester; reports latency and enable activity.
    task automatic run_txn(input int idx, input bit w, input logic [AS-1:0] a,
                           input logic [WS-1:0] d, input int wt, input bit to,
                           output int ack_cyc, output int w_cyc, output int r_cyc,
                           output bit addr_ok);
        mem_wait = wt;
        ack_cyc  = -1;
        w_cyc    = 0;
        r_cyc    = 0;
        addr_ok  = 1'b1;
        @(negedge clock);
        drive(idx, w, a, d);
        push_exp(idx, w, a, d, to);
        for (int k = 1; k <= 200; k++) begin
            @(negedge clock);
            if (mem_w_en) begin
                w_cyc++;
                if (mem_w_addr !== a || mem_w_data !== d) addr_ok = 1'b0;
            end
            if (mem_r_en) begin
                r_cyc++;
                if (mem_r_addr !== a) addr_ok = 1'b0;
            end
            if (ack[idx] === 1'b1) begin
                ack_cyc  = k + 1;
                req[idx] = 1'b0;
                break;
            end
        end
        req[idx] = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset     = 1'b0;
        req       = 2'b00;
        we        = 2'b00;
        exp_rdata = '0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        req      = 2'b00;
        we       = 2'b00;
        addr     = '0;
        wdata    = '0;
        mem_hold = 1'b0;
        mem_wait = 0;
        exp_rdata = '0;
        for (int i = 0; i < 16; i++) begin
            mem[i]     = WS'(8'h40 + i);
            ref_mem[i] = WS'(8'h40 + i);
        end
        #1;
        n_checks++;
        if ({ack, err, rdata, mem_r_en, mem_w_en} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs ack=%b err=%b rdata=%h r_en=%b w_en=%b want all 0",
                     ack, err, rdata, mem_r_en, mem_w_en);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({ack, mem_r_en, mem_w_en} !== '0) begin
            n_fail++;
            $display("FAIL idle_quiet ack=%b r_en=%b w_en=%b want 0", ack, mem_r_en, mem_w_en);
        end
    endtask

    task automatic test_write_a();
        int ac, wc, rc;
        bit ok;
        run_txn(0, 1'b1, 4'd3, 8'hA5, 0, 1'b0, ac, wc, rc, ok);
        n_checks++; if (ac !== 4) begin n_fail++; $display("FAIL wr_ack_cycle got %0d want 4", ac); end
        n_checks++; if (wc !== 2) begin n_fail++; $display("FAIL wr_en_cycles got %0d want 2", wc); end
        n_checks++; if (rc !== 0) begin n_fail++; $display("FAIL wr_r_en_cycles got %0d want 0", rc); end
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL wr_addr_data got bad want addr 3 data a5"); end
    endtask

    task automatic test_read_b();
        int ac, wc, rc;
        bit ok;
        run_txn(1, 1'b0, 4'd3, 8'h00, 0, 1'b0, ac, wc, rc, ok);
        n_checks++; if (ac !== 4) begin n_fail++; $display("FAIL rd_ack_cycle got %0d want 4", ac); end
        n_checks++; if (rc !== 2 || wc !== 0) begin n_fail++; $display("FAIL rd_en_cycles got r=%0d w=%0d want r=2 w=0", rc, wc); end
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rd_addr got bad want 3"); end
        repeat (2) @(negedge clock);
        n_checks++; if (rdata !== 8'hA5) begin n_fail++; $display("FAIL rdata_hold got %h want a5", rdata); end
    endtask

    task automatic test_write_keeps_rdata();
        int ac, wc, rc;
        bit ok;
        run_txn(0, 1'b1, 4'd7, 8'h3C, 0, 1'b0, ac, wc, rc, ok);
        n_checks++; if (rdata !== 8'hA5) begin n_fail++; $display("FAIL rdata_after_write got %h want a5", rdata); end
        run_txn(1, 1'b0, 4'd7, 8'h00, 0, 1'b0, ac, wc, rc, ok);
        n_checks++; if (ac !== 4) begin n_fail++; $display("FAIL rd7_ack_cycle got %0d want 4", ac); end
    endtask

    task automatic test_wait_states();
        int ac, wc, rc;
        bit ok;
        run_txn(0, 1'b0, 4'd3, 8'h00, 2, 1'b0, ac, wc, rc, ok);
        n_checks++; if (ac !== 6) begin n_fail++; $display("FAIL wait_ack_cycle got %0d want 6", ac); end
        n_checks++; if (rc !== 4) begin n_fail++; $display("FAIL wait_en_cycles got %0d want 4", rc); end
        mem_wait = 0;
    endtask

    task automatic test_round_robin();
        logic [1:0] order [4];
        int         seen = 0;
        apply_reset();
        @(negedge clock);
        drive(0, 1'b0, 4'd3, 8'h00);
        drive(1, 1'b0, 4'd7, 8'h00);
        for (int i = 0; i < 4; i++) push_exp(i % 2, 1'b0, (i % 2 == 0) ? 4'd3 : 4'd7, 8'h00, 1'b0);
        for (int k = 0; k < 100 && seen < 4; k++) begin
            @(negedge clock);
            if (ack !== 2'b00) begin
                order[seen] = ack;
                seen++;
            end
        end
        req = 2'b00;
        n_checks++; if (seen !== 4) begin n_fail++; $display("FAIL rr_count got %0d want 4", seen); end
        for (int i = 0; i < seen; i++) begin
            n_checks++;
            if (order[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL rr_order[%0d] got %b want %b", i, order[i], (i % 2 == 0) ? 2'b01 : 2'b10);
            end
        end
    endtask

    task automatic test_mid_reset();
        int ac, wc, rc;
        bit ok;
        bit quiet = 1'b1;
        mem_hold = 1'b1;
        @(negedge clock);
        drive(0, 1'b1, 4'd9, 8'h77);
        repeat (4) @(negedge clock);
        n_checks++; if (mem_w_en !== 1'b1) begin n_fail++; $display("FAIL midrst_wait_en got %b want 1", mem_w_en); end
        #3 reset = 1'b0;
        #1;
        n_checks++;
        if ({ack, err, rdata, mem_r_en, mem_w_en} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs ack=%b err=%b rdata=%h r_en=%b w_en=%b want all 0",
                     ack, err, rdata, mem_r_en, mem_w_en);
        end
        req       = 2'b00;
        mem_hold  = 1'b0;
        exp_rdata = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (ack !== 2'b00 || mem_w_en !== 1'b0) quiet = 1'b0;
        end
        n_checks++; if (quiet !== 1'b1) begin n_fail++; $display("FAIL midrst_no_ack got activity want none"); end
        run_txn(0, 1'b0, 4'd9, 8'h00, 0, 1'b0, ac, wc, rc, ok);
        n_checks++; if (ac !== 4) begin n_fail++; $display("FAIL post_rst_ack_cycle got %0d want 4", ac); end
    endtask

`ifdef MEMORY_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        int ac, wc, rc;
        bit ok;
        mem_hold = 1'b1;
        run_txn(0, 1'b0, 4'd3, 8'h00, 0, 1'b1, ac, wc, rc, ok);
        mem_hold = 1'b0;
        n_checks++; if (ac !== int'(TO) + 3) begin n_fail++; $display("FAIL to_ack_cycle got %0d want %0d", ac, TO + 3); end
        n_checks++; if (rc !== int'(TO) + 1) begin n_fail++; $display("FAIL to_en_cycles got %0d want %0d", rc, TO + 1); end
    endtask
`else
    task automatic test_no_timeout();
        bit stuck_ok = 1'b1;
        bit got_ack  = 1'b0;
        mem_hold = 1'b1;
        @(negedge clock);
        drive(0, 1'b0, 4'd5, 8'h00);
        push_exp(0, 1'b0, 4'd5, 8'h00, 1'b0);
        @(negedge clock);
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (ack !== 2'b00 || err !== 2'b00 || mem_r_en !== 1'b1) stuck_ok = 1'b0;
        end
        n_checks++; if (stuck_ok !== 1'b1) begin n_fail++; $display("FAIL no_to_wait got early exit want held in wait"); end
        mem_hold = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (ack[0] === 1'b1) begin
                got_ack = 1'b1;
                break;
            end
        end
        req = 2'b00;
        n_checks++; if (got_ack !== 1'b1) begin n_fail++; $display("FAIL no_to_release got no ack want ack"); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_a();
        test_read_b();
        test_write_keeps_rdata();
        test_wait_states();
        test_round_robin();
        test_mid_reset();
`ifdef MEMORY_ARBITER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clock);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain got %0d pending want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
